// File: rtl/conv1d_ctrl.sv
// Frame sequencer for one conv1d core: shadow/active weight banks, sample gating,
// result counting for drain detection, and a flush pulse between frames.
module conv1d_ctrl #(
   parameter int unsigned DATA_WIDTH  = 12,
   parameter int unsigned FILTER_SIZE = 5,
   parameter int unsigned FRAME_LEN   = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  cfg_ready_in,
   input  logic                  cfg_valid_in,
   input  logic [DATA_WIDTH-1:0] cfg_data_in,
   output logic                  ctrl_ready_in,
   input  logic                  ctrl_valid_in,
   input  logic [DATA_WIDTH-1:0] ctrl_data_in,
   input  logic                  conv_ready_in,
   output logic                  conv_valid_out,
   output logic [DATA_WIDTH-1:0] conv_data_out,
   output logic [DATA_WIDTH-1:0] conv_weights [0:FILTER_SIZE-1],
   output logic [DATA_WIDTH-1:0] conv_bias,
   output logic                  conv_flush,
   input  logic                  mon_valid,
   input  logic                  mon_ready,
   output logic                  frame_done,
   output logic                  cfg_pending
);

   localparam int unsigned CntW = $clog2(FRAME_LEN + 1);
   localparam int unsigned KW   = $clog2(FILTER_SIZE + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_LEN - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(FRAME_LEN);
   localparam logic [KW-1:0]   KLast   = KW'(FILTER_SIZE);

   typedef enum logic [1:0] {StEmpty, StFlush, StRun, StDrain} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       in_cnt_q, in_cnt_d;
   logic [CntW-1:0]       out_cnt_q, out_cnt_d;
   logic                  frame_done_q, frame_done_d;
   logic                  commit;

   logic [KW-1:0]         k_q;
   logic [DATA_WIDTH-1:0] shadow_w_q [0:FILTER_SIZE-1];
   logic [DATA_WIDTH-1:0] shadow_b_q;
   logic                  shadow_full_q;
   logic [DATA_WIDTH-1:0] act_w_q [0:FILTER_SIZE-1];
   logic [DATA_WIDTH-1:0] act_b_q;

   logic cfg_hs, mon_hs, in_hs;

   // Held low during reset so no config word is accepted into a bank being cleared.
   assign cfg_ready_in = ~shadow_full_q & ~rst;
   assign cfg_hs       = cfg_valid_in & cfg_ready_in;
   assign mon_hs       = mon_valid & mon_ready;
   assign in_hs        = ctrl_valid_in & conv_ready_in;
   assign cfg_pending  = shadow_full_q;
   assign frame_done   = frame_done_q;
   assign conv_weights = act_w_q;
   assign conv_bias    = act_b_q;

   // Config loader: words 0..FILTER_SIZE-1 are weights, the last word is the bias.
   always_ff @(posedge clk) begin
      if (rst) begin
         k_q           <= '0;
         shadow_b_q    <= '0;
         shadow_full_q <= 1'b0;
         for (int i = 0; i < int'(FILTER_SIZE); i++) shadow_w_q[i] <= '0;
      end else if (cfg_hs) begin
         if (k_q == KLast) begin
            shadow_b_q    <= cfg_data_in;
            shadow_full_q <= 1'b1;
            k_q           <= '0;
         end else begin
            for (int i = 0; i < int'(FILTER_SIZE); i++) begin
               if (k_q == KW'(i)) shadow_w_q[i] <= cfg_data_in;
            end
            k_q <= k_q + 1'b1;
         end
      end else if (commit) begin
         shadow_full_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_b_q <= '0;
         for (int i = 0; i < int'(FILTER_SIZE); i++) act_w_q[i] <= '0;
      end else if (commit) begin
         act_b_q <= shadow_b_q;
         act_w_q <= shadow_w_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StEmpty;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      in_cnt_d       = in_cnt_q;
      out_cnt_d      = out_cnt_q;
      frame_done_d   = 1'b0;
      commit         = 1'b0;
      ctrl_ready_in  = 1'b0;
      conv_valid_out = 1'b0;
      conv_data_out  = '0;
      conv_flush     = 1'b0;

      if ((state_q == StRun || state_q == StDrain) && mon_hs && out_cnt_q != FullCnt) begin
         out_cnt_d = out_cnt_q + 1'b1;
      end

      case (state_q)
         StEmpty: begin
            if (shadow_full_q) begin
               commit  = 1'b1;
               state_d = StFlush;
            end
         end
         StFlush: begin
            conv_flush = 1'b1;
            in_cnt_d   = '0;
            out_cnt_d  = '0;
            state_d    = StRun;
         end
         StRun: begin
            conv_valid_out = ctrl_valid_in;
            conv_data_out  = ctrl_data_in;
            ctrl_ready_in  = conv_ready_in;
            if (in_hs) begin
               in_cnt_d = in_cnt_q + 1'b1;
               if (in_cnt_q == LastCnt) state_d = StDrain;
            end
         end
         StDrain: begin
            // Registered shadow_full: a bank finishing this same cycle waits a frame.
            if (out_cnt_q == FullCnt || (out_cnt_q == LastCnt && mon_hs)) begin
               frame_done_d = 1'b1;
               commit       = shadow_full_q;
               state_d      = StFlush;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

endmodule
